// File: rtl/seg_pkg.sv
// seg_pkg: shared 7-segment codes, segment bit positions and scan FSM state.
package seg_pkg;
    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;
    // Active-low a..g patterns for hex digits 0..F, indexed by nibble value
    localparam logic [6:0] SEG_CODES [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    typedef enum logic [1:0] {IDLE, SETTLE, HELD} seg_state_t;
endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: maps an active-low a..g pattern to {valid, hex nibble}; unknown patterns give valid=0, nibble=0.
module seg7_pattern_decode
    import seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic       valid,
    output logic [3:0] nibble
);
    always_comb begin
        valid  = 1'b0;
        nibble = 4'd0;
        for (int n = 0; n < 16; n++) begin
            if (seg == SEG_CODES[n]) begin
                valid  = 1'b1;
                nibble = 4'(n);
            end
        end
    end
endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: rebuilds 4-digit hex frames from multiplexed 7-segment scan outputs.
// Define SEG_SCAN_ERR_EN to report multi-hot selects and unknown patterns on err instead of capturing them.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  Dis_data,
    input  logic [3:0]  Dis_wich,
    output logic [15:0] frame_digits,
    output logic [3:0]  frame_dp,
    output logic        frame_valid,
    input  logic        frame_ready,
    output logic        overrun,
    output logic        err
);
    logic [11:0] in_q;
    logic [7:0]  cnt, cnt_nx;
    seg_state_t  state;
    logic [15:0] asm_digits;
    logic [3:0]  asm_dp, mask, mask_kept, sel_n, nibble, cap_nib;
    logic [1:0]  idx;
    logic        same, blank, onehot, pat_ok, stable, capture, bad, full;

    seg7_pattern_decode u_dec (.seg(in_q[6:0]), .valid(pat_ok), .nibble(nibble));

    // Decisions look at the sample being registered this edge so capture lands STABLE_CYCLES after in_q changes
    assign same      = {Dis_wich, Dis_data} == in_q;
    assign cnt_nx    = !same ? 8'd0 : (cnt == 8'(STABLE_CYCLES)) ? cnt : cnt + 8'd1;
    assign blank     = Dis_wich == 4'hF;
    assign stable    = state == SETTLE && !blank && cnt_nx == 8'(STABLE_CYCLES);
    assign sel_n     = ~in_q[11:8];
    assign onehot    = $onehot(sel_n);
    assign idx       = sel_n[3] ? 2'd3 : sel_n[2] ? 2'd2 : sel_n[1] ? 2'd1 : 2'd0;
    assign cap_nib   = pat_ok ? nibble : 4'd0;
    assign full      = mask == 4'hF;
    assign mask_kept = full ? 4'h0 : mask;
`ifdef SEG_SCAN_ERR_EN
    assign bad       = !onehot || !pat_ok;
    assign capture   = stable && !bad;
`else
    assign bad       = 1'b0;
    assign capture   = stable && onehot;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_q         <= 12'hFFF;
            cnt          <= 8'd0;
            state        <= IDLE;
            mask         <= 4'h0;
            asm_digits   <= 16'h0;
            asm_dp       <= 4'h0;
            frame_digits <= 16'h0;
            frame_dp     <= 4'h0;
            frame_valid  <= 1'b0;
            overrun      <= 1'b0;
            err          <= 1'b0;
        end else begin
            in_q    <= {Dis_wich, Dis_data};
            cnt     <= cnt_nx;
            state   <= blank ? IDLE : (stable || (state == HELD && same)) ? HELD : SETTLE;
            err     <= stable && bad;
            overrun <= full && frame_valid && !frame_ready;
            mask    <= capture ? mask_kept | (4'b0001 << idx) : mask_kept;
            if (capture) begin
                asm_digits[{idx, 2'b00} +: 4] <= cap_nib;
                asm_dp[idx]                   <= ~in_q[SEG_DP];
            end
            if (full && (!frame_valid || frame_ready)) begin
                frame_digits <= asm_digits;
                frame_dp     <= asm_dp;
                frame_valid  <= 1'b1;
            end else if (frame_ready) begin
                frame_valid  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: directed vector bench for seg_scan_decoder (STABLE_CYCLES=4), honours SEG_SCAN_ERR_EN.
module tb_seg_scan_decoder;
    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  Dis_data;
    logic [3:0]  Dis_wich;
    logic [15:0] frame_digits;
    logic [3:0]  frame_dp;
    logic        frame_valid;
    logic        frame_ready;
    logic        overrun;
    logic        err;

    int checks = 0;
    int errors = 0;
    int frames = 0;
    int overruns = 0;
    int errs = 0;
    logic [15:0] last_digits = 16'h0;
    logic [3:0]  last_dp = 4'h0;

    seg_scan_decoder #(.STABLE_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .Dis_data(Dis_data), .Dis_wich(Dis_wich),
        .frame_digits(frame_digits), .frame_dp(frame_dp), .frame_valid(frame_valid),
        .frame_ready(frame_ready), .overrun(overrun), .err(err)
    );

    always #5 clk = ~clk;

    // Count handshakes and pulses between edges, after stimulus has settled
    always begin
        @(negedge clk);
        #2;
        if (frame_valid && frame_ready) begin
            frames++;
            last_digits = frame_digits;
            last_dp = frame_dp;
        end
        if (overrun) overruns++;
        if (err) errs++;
    end

    typedef struct {
        logic [15:0] digits;
        logic [3:0]  dp;
        int          hold;
        int          exp_frames;
    } vec_t;

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic show(input int i, input logic [6:0] seg, input logic dp, input int hold);
        Dis_wich = ~(4'b0001 << i);
        Dis_data = {~dp, seg};
        repeat (hold) @(negedge clk);
    endtask

    task automatic blank(input int n);
        Dis_wich = 4'hF;
        Dis_data = 8'hFF;
        repeat (n) @(negedge clk);
    endtask

    task automatic scan(input logic [15:0] d, input logic [3:0] dp, input int hold);
        for (int i = 3; i >= 0; i--) show(i, seg_of(d[4*i +: 4]), dp[i], hold);
    endtask

    initial begin
        vec_t vecs[6];
        int f0, o0, e0;
        vecs[0] = '{16'h1234, 4'b0000, 8, 1};
        vecs[1] = '{16'h5A0F, 4'b1010, 5, 1};
        vecs[2] = '{16'h1234, 4'b0000, 4, 0};
        vecs[3] = '{16'h89BC, 4'b0001, 6, 1};
        vecs[4] = '{16'h1234, 4'b0000, 3, 0};
        vecs[5] = '{16'hDE67, 4'b1111, 7, 1};

        reset = 1'b0;
        frame_ready = 1'b0;
        Dis_wich = 4'hF;
        Dis_data = 8'hFF;
        repeat (3) @(negedge clk);
        chk("rst_digits", 32'(frame_digits), 32'h0);
        chk("rst_dp", 32'(frame_dp), 32'h0);
        chk("rst_valid", 32'(frame_valid), 32'h0);
        chk("rst_overrun", 32'(overrun), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        reset = 1'b1;
        @(negedge clk);

        frame_ready = 1'b1;
        for (int v = 0; v < 6; v++) begin
            f0 = frames;
            scan(vecs[v].digits, vecs[v].dp, vecs[v].hold);
            blank(4);
            chk($sformatf("vec%0d_frames", v), 32'(frames - f0), 32'(vecs[v].exp_frames));
            if (vecs[v].exp_frames == 1) begin
                chk($sformatf("vec%0d_digits", v), 32'(last_digits), 32'(vecs[v].digits));
                chk($sformatf("vec%0d_dp", v), 32'(last_dp), 32'(vecs[v].dp));
            end
            chk($sformatf("vec%0d_valid_low", v), 32'(frame_valid), 32'h0);
        end

        // Second frame while first is unaccepted is dropped with an overrun pulse
        frame_ready = 1'b0;
        f0 = frames;
        o0 = overruns;
        scan(16'hABCD, 4'h0, 8);
        scan(16'h0F0F, 4'h0, 8);
        blank(4);
        chk("ovr_digits", 32'(frame_digits), 32'hABCD);
        chk("ovr_valid", 32'(frame_valid), 32'h1);
        chk("ovr_pulses", 32'(overruns - o0), 32'h1);
        frame_ready = 1'b1;
        @(negedge clk);
        chk("ovr_valid_drop", 32'(frame_valid), 32'h0);
        chk("ovr_accepted", 32'(last_digits), 32'hABCD);

        // Accept and new frame land on the same edge
        frame_ready = 1'b0;
        o0 = overruns;
        scan(16'h2468, 4'h0, 8);
        blank(2);
        for (int i = 3; i >= 1; i--) show(i, seg_of(4'(16'hC0DE >> (4*i))), 1'b0, 8);
        show(0, seg_of(4'hE), 1'b0, 5);
        f0 = frames;
        frame_ready = 1'b1;
        @(negedge clk);
        chk("b2b_valid", 32'(frame_valid), 32'h1);
        chk("b2b_digits", 32'(frame_digits), 32'hC0DE);
        chk("b2b_first_taken", 32'(last_digits), 32'h2468);
        @(negedge clk);
        chk("b2b_second_taken", 32'(last_digits), 32'hC0DE);
        chk("b2b_no_overrun", 32'(overruns - o0), 32'h0);
        blank(4);

        // Unlisted pattern 0x7F on digit 2
        f0 = frames;
        e0 = errs;
        show(3, seg_of(4'h9), 1'b0, 8);
        show(2, 7'h7F, 1'b0, 8);
        show(1, seg_of(4'h5), 1'b0, 8);
        show(0, seg_of(4'h3), 1'b0, 8);
        blank(4);
`ifdef SEG_SCAN_ERR_EN
        chk("bad_pat_err", 32'(errs - e0), 32'h1);
        chk("bad_pat_noframe", 32'(frames - f0), 32'h0);
        show(2, seg_of(4'h7), 1'b0, 8);
        blank(4);
        chk("bad_pat_refill", 32'(frames - f0), 32'h1);
        chk("bad_pat_digits", 32'(last_digits), 32'h9753);
`else
        chk("bad_pat_err", 32'(errs - e0), 32'h0);
        chk("bad_pat_frame", 32'(frames - f0), 32'h1);
        chk("bad_pat_digits", 32'(last_digits), 32'h9053);
`endif

        // Multi-hot select held stable
        f0 = frames;
        e0 = errs;
        Dis_wich = 4'b1100;
        Dis_data = {1'b1, seg_of(4'h8)};
        repeat (10) @(negedge clk);
        blank(4);
`ifdef SEG_SCAN_ERR_EN
        chk("multihot_err", 32'(errs - e0), 32'h1);
`else
        chk("multihot_err", 32'(errs - e0), 32'h0);
`endif
        chk("multihot_noframe", 32'(frames - f0), 32'h0);

        // Reset after two digits discards the partial frame
        show(3, seg_of(4'h1), 1'b0, 8);
        show(2, seg_of(4'h2), 1'b1, 8);
        show(1, seg_of(4'h3), 1'b0, 2);
        reset = 1'b0;
        #1;
        chk("mid_rst_digits", 32'(frame_digits), 32'h0);
        chk("mid_rst_dp", 32'(frame_dp), 32'h0);
        chk("mid_rst_valid", 32'(frame_valid), 32'h0);
        chk("mid_rst_overrun", 32'(overrun), 32'h0);
        chk("mid_rst_err", 32'(err), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        f0 = frames;
        show(1, seg_of(4'h7), 1'b0, 8);
        show(0, seg_of(4'h8), 1'b0, 8);
        blank(4);
        chk("post_rst_partial", 32'(frames - f0), 32'h0);
        scan(16'h5678, 4'h0, 8);
        blank(4);
        chk("post_rst_frames", 32'(frames - f0), 32'h1);
        chk("post_rst_digits", 32'(last_digits), 32'h5678);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
